// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory path: core count, timeout default,
// word width and the access sequencer state encoding.
package gpu_mem_pkg;

  localparam int DEF_N_CORES        = 4;
  localparam int DEF_N_CORES_LOG    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int WORD_W             = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } mem_seq_state_e;

endpackage

// File: rtl/mem_access_sequencer.sv
// Sequences one multi-core load/store through the shared memory controller:
// latch request, pulse MRead/MWrite, wait for MReady (with timeout), capture loads.
module mem_access_sequencer
  import gpu_mem_pkg::*;
#(
  parameter int N_CORES        = DEF_N_CORES,
  parameter int N_CORES_LOG    = DEF_N_CORES_LOG,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             is_store,
  input  logic [N_CORES-1:0]               core_mask,
  input  logic [N_CORES-1:0][WORD_W-1:0]   core_addr,
  input  logic [N_CORES-1:0][WORD_W-1:0]   core_wdata,
  output logic                             MRead,
  output logic                             MWrite,
  input  logic                             MReady,
  output logic [N_CORES-1:0]               en,
  output logic [N_CORES-1:0][WORD_W-1:0]   addr,
  output logic [N_CORES-1:0][WORD_W-1:0]   data,
  input  logic [N_CORES-1:0][WORD_W-1:0]   q,
  output logic [N_CORES-1:0][WORD_W-1:0]   ld_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_seq_state_e                   state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             to_q, to_d;
  logic                             accept;
  logic                             store_q;
  logic [N_CORES-1:0]               mask_q;
  logic [N_CORES-1:0][WORD_W-1:0]   addr_q, data_q, ld_q;
  logic                             cap;
  logic [N_CORES-1:0]               cap_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    accept  = 1'b0;
    MRead   = 1'b0;
    MWrite  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          to_d    = 1'b0;
          state_d = (|core_mask) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        MRead   = ~store_q;
        MWrite  = store_q;
        state_d = S_SETTLE;
      end
      // MReady is deliberately ignored here; the controller needs a cycle to drop it.
      S_SETTLE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (MReady) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      store_q <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      if (accept) begin
        store_q <= is_store;
        mask_q  <= core_mask;
        addr_q  <= core_addr;
        data_q  <= core_wdata;
      end
    end
  end

  // Empty-mask accesses latch mask_q=0, so they never select a capture lane.
  assign cap = (state_q == S_DONE) && !store_q && !to_q;

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    localparam logic [N_CORES_LOG-1:0] IDX = N_CORES_LOG'(g);
    assign cap_sel[g] = cap && mask_q[IDX];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_q <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++)
        if (cap_sel[i]) ld_q[i] <= q[i];
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = done && to_q;
  assign en      = busy ? mask_q : '0;
  assign addr    = addr_q;
  assign data    = data_q;
  assign ld_data = ld_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small latency-programmable
// memory controller model driving MReady.
module tb_mem_access_sequencer;

  logic              clk = 1'b0;
  logic              reset, start, is_store, MReady;
  logic              MRead, MWrite, busy, done, err;
  logic [3:0]        core_mask, en;
  logic [3:0][15:0]  core_addr, core_wdata, addr, data, q, ld_data;

  int total = 0;
  int bad   = 0;

  // controller model: after a request, MReady drops for lat cycles
  int   lat      = 1;
  logic hold_low = 1'b0;
  int   ctl_cnt  = 0;
  int   rd_total = 0;
  int   wr_total = 0;

  logic [3:0]       exp_en;
  logic [63:0]      exp_data;
  logic             stable;

  mem_access_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .core_mask(core_mask), .core_addr(core_addr), .core_wdata(core_wdata),
    .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
    .en(en), .addr(addr), .data(data), .q(q), .ld_data(ld_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (MRead === 1'b1)  rd_total++;
    if (MWrite === 1'b1) wr_total++;
    if (MRead === 1'b1 || MWrite === 1'b1) ctl_cnt <= lat;
    else if (ctl_cnt != 0)                 ctl_cnt <= ctl_cnt - 1;
  end

  assign MReady = (ctl_cnt == 0) && !hold_low;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      start = 1'b0;
      n++;
      if (busy && (en !== exp_en || data !== exp_data)) stable = 1'b0;
    end while (!done && n < 200);
    if (!done) chk("wait_done_bound", 64'd0, 64'd1);
  endtask

  int   n, rd0, wr0;
  logic done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; core_mask = '0;
    core_addr = '0; core_wdata = '0; q = '0;
    step(); step();
    chk("rst_ctl", {MRead, MWrite, busy, done, err, en}, '0);
    chk("rst_addr", addr, '0);
    chk("rst_data", data, '0);
    chk("rst_ld", ld_data, '0);
    reset = 1'b0;
    step();

    // load, controller latency 3 -> two extra WAIT cycles
    lat = 3; rd0 = rd_total; wr0 = wr_total; stable = 1'b1;
    core_mask = 4'b0101;
    core_addr = {16'h0, 16'h0020, 16'h0, 16'h0010};
    core_wdata = '0;
    q = {16'hBEEF, 16'h5555, 16'hDEAD, 16'hAAAA};
    exp_en = 4'b0101; exp_data = '0;
    is_store = 1'b0; start = 1'b1;
    wait_done(n);
    chk("ld_latency", n, 6);
    chk("ld_err", err, 0);
    chk("ld_addr", addr, {16'h0, 16'h0020, 16'h0, 16'h0010});
    chk("ld_mread", rd_total - rd0, 1);
    chk("ld_mwrite", wr_total - wr0, 0);
    chk("ld_stable", stable, 1);
    step();
    chk("ld_data", ld_data, {16'h0, 16'h5555, 16'h0, 16'hAAAA});
    chk("ld_idle", {busy, en}, '0);

    // store, all cores
    lat = 2; rd0 = rd_total; wr0 = wr_total; stable = 1'b1;
    core_mask = 4'b1111;
    core_wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    q = {16'h9999, 16'h8888, 16'h7777, 16'h6666};
    exp_en = 4'b1111; exp_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    is_store = 1'b1; start = 1'b1;
    wait_done(n);
    chk("st_latency", n, 5);
    chk("st_mwrite", wr_total - wr0, 1);
    chk("st_mread", rd_total - rd0, 0);
    chk("st_stable", stable, 1);
    step();
    chk("st_ld_keep", ld_data, {16'h0, 16'h5555, 16'h0, 16'hAAAA});

    // empty mask
    rd0 = rd_total; wr0 = wr_total; stable = 1'b1;
    core_mask = 4'b0000; exp_en = 4'b0000; exp_data = core_wdata;
    is_store = 1'b0; start = 1'b1;
    wait_done(n);
    chk("empty_latency", n, 1);
    chk("empty_err", err, 0);
    step();
    chk("empty_req", (rd_total - rd0) + (wr_total - wr0), 0);
    chk("empty_ld_keep", ld_data, {16'h0, 16'h5555, 16'h0, 16'hAAAA});
    chk("empty_idle", busy, 0);

    // timeout: MReady never returns
    hold_low = 1'b1; stable = 1'b1;
    core_mask = 4'b0001; exp_en = 4'b0001; exp_data = core_wdata;
    q = {16'h1, 16'h2, 16'h3, 16'h1234};
    is_store = 1'b0; start = 1'b1;
    wait_done(n);
    chk("to_latency", n, 67);
    chk("to_err", err, 1);
    step();
    chk("to_idle", {busy, done, err}, 3'b000);
    chk("to_ld_keep", ld_data, {16'h0, 16'h5555, 16'h0, 16'hAAAA});

    // reset while waiting
    core_mask = 4'b0011; is_store = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst", {busy, done, en}, '0);
    chk("mid_addr", addr, '0);
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) done_seen = 1'b1;
    end
    chk("mid_no_done", done_seen, 0);
    hold_low = 1'b0;
    step(); step();

    // start while busy, second start lands in SETTLE
    lat = 1; rd0 = rd_total; stable = 1'b1;
    core_mask = 4'b0010; exp_en = 4'b0010; exp_data = core_wdata;
    is_store = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step();
    core_mask = 4'b1000; start = 1'b1;
    wait_done(n);
    chk("busy_latency", n, 2);
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy) done_seen = 1'b1;
    end
    chk("busy_no_rerun", done_seen, 0);
    chk("busy_mread", rd_total - rd0, 1);
    chk("busy_stable", stable, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of cores sharing the memory controller.
REQ-002 SHALL have parameter N_CORES_LOG, default 2, log2(N_CORES).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request from the control unit to begin one load/store.
REQ-007 SHALL have port is_store, input, 1, 1 = store, 0 = load; sampled with start.
REQ-008 SHALL have port core_mask, input, N_CORES, active cores for this access; sampled with start.
REQ-009 SHALL have port core_addr, input, N_CORES x 16, per-core addresses; sampled with start.
REQ-010 SHALL have port core_wdata, input, N_CORES x 16, per-core store data; sampled with start.
REQ-011 SHALL have port MRead, output, 1, one-cycle load request to the memory controller.
REQ-012 SHALL have port MWrite, output, 1, one-cycle store request to the memory controller.
REQ-013 SHALL have port MReady, input, 1, controller idle/complete flag.
REQ-014 SHALL have port en, output, N_CORES, latched core_mask to the controller.
REQ-015 SHALL have port addr, output, N_CORES x 16, latched addresses to the controller.
REQ-016 SHALL have port data, output, N_CORES x 16, latched store data to the controller.
REQ-017 SHALL have port q, input, N_CORES x 16, per-core load data from the controller.
REQ-018 SHALL have port ld_data, output, N_CORES x 16, captured load results per core.
REQ-019 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-020 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-021 SHALL have port err, output, 1, one-cycle timeout pulse, coincident with done.

Function
REQ-022 SHALL implement states IDLE, ISSUE, SETTLE, WAIT, DONE.
REQ-023 SHALL, in IDLE with start=1 and core_mask!=0, latch is_store/core_mask/core_addr/core_wdata and go to ISSUE.
REQ-024 SHALL, in IDLE with start=1 and core_mask=0, go directly to DONE; MRead/MWrite stay 0.
REQ-025 SHALL assert exactly one of MRead (load) or MWrite (store) for the single ISSUE cycle, then go to SETTLE.
REQ-026 SHALL spend exactly one cycle in SETTLE, ignoring MReady, so the controller can drop MReady.
REQ-027 SHALL, in WAIT, go to DONE on the first cycle MReady=1.
REQ-028 SHALL hold en/addr/data at the latched values from ISSUE through DONE; en=0 in IDLE.
REQ-029 SHALL, in DONE on a load, copy q[i] into ld_data[i] for each latched-mask bit i; other entries unchanged.
REQ-030 SHALL leave ld_data unchanged on stores, empty-mask accesses and timeouts.
REQ-031 SHALL pulse done for the single DONE cycle, then return to IDLE.
REQ-032 SHALL count WAIT cycles; if the count reaches TIMEOUT_CYCLES with MReady=0, go to DONE with err=1.
REQ-033 SHALL ignore start whenever busy=1, including in DONE.
REQ-034 SHALL give a minimum latency of 4 cycles from start to done for a non-empty mask: start edge, then ISSUE, SETTLE, first WAIT, DONE.

Reset
REQ-035 SHALL, on reset=1 at a clock edge, enter IDLE and clear the WAIT counter.
REQ-036 SHALL, on that edge, drive MRead, MWrite, en, busy, done and err to 0.
REQ-037 SHALL, on that edge, drive addr, data and ld_data to 0.
REQ-038 SHALL let reset take priority over start and abort any in-flight access without a done pulse.

Structure
REQ-039 SHALL take N_CORES, N_CORES_LOG, the state enum and TIMEOUT_CYCLES default from the shared package gpu_mem_pkg, which the memory controller also uses.
REQ-040 SHALL be one flat module; the timeout counter is inline, with no sub-module.

Verification
REQ-041 SHALL test a load: mask=4'b0101, addr0=0x0010, addr2=0x0020, controller model returns q0=0xAAAA, q2=0x5555 -> one MRead pulse, done at cycle 4+N, ld_data[0]=0xAAAA, ld_data[2]=0x5555, ld_data[1]/[3] unchanged.
REQ-042 SHALL test a store: mask=4'b1111, data=0x1111..0x4444 -> one MWrite pulse, no MRead, en/data stable until done, ld_data unchanged.
REQ-043 SHALL test an empty mask: start with mask=0 -> done 1 cycle later, MRead=MWrite=0, err=0.
REQ-044 SHALL test a timeout: MReady held 0 -> done=err=1 after exactly 64 WAIT cycles, then IDLE.
REQ-045 SHALL test reset mid-operation: reset asserted in WAIT -> next cycle IDLE, en=0, busy=0, no done.
REQ-046 SHALL test start while busy: second start in SETTLE -> ignored, exactly one MRead pulse.
